// File: rtl/apb4_slave_pkg.sv
// Shared types and helpers for the APB4 wait-state completer: FSM states,
// LFSR constants and the address decode used at the setup edge.
package apb4_slave_pkg;

    typedef enum logic {IDLE, ACCESS} state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic        err;
        logic [29:0] idx;
    } decode_t;

    function automatic decode_t decode(input logic [31:0] paddr,
                                       input logic        pwrite,
                                       input logic [31:0] baseAddr,
                                       input logic [31:0] sizeBytes);
        decode_t     res;
        logic [31:0] off;
        off     = paddr - baseAddr;
        res.idx = off[31:2];
        res.err = (paddr[1:0] != 2'b00) || (off >= sizeBytes) ||
                  (pwrite && (off[31:2] == 30'd0));
        return res;
    endfunction

endpackage

// File: rtl/apb_wait_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the source of random wait counts.
module apb_wait_lfsr
    import apb4_slave_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/apb4_wait_state_slave.sv
// APB4 completer with a word register bank, fixed or random wait states,
// error responses and saturating write/error counters.
module apb4_wait_state_slave
    import apb4_slave_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 2,
    parameter int          MAX_WAIT    = 7,
    parameter logic [31:0] ID_VALUE    = 32'hA5B4_0001
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PSLVERROR,
    output logic        PREADY,
    output logic [15:0] wr_count,
    output logic [7:0]  err_count
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic [15:0]       wrCount_q, wrCount_d;
    logic [7:0]        errCount_q, errCount_d;
    logic [31:0]       regs_q [NUM_REGS];
    logic [31:0]       regs_d [NUM_REGS];

    logic [15:0]       lfsr;
    logic [CNT_W-1:0]  waitLoad;
    logic              ready;
    decode_t           dec;
    logic [31:0]       rdVal;

    apb_wait_lfsr u_lfsr (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .lfsr_o  (lfsr)
    );

    assign waitLoad = (WAIT_MODE == 0) ? CNT_W'(WAIT_CYCLES) : CNT_W'(lfsr & 16'(MAX_WAIT));
    assign dec      = decode(PADDR, PWRITE, BASE_ADDR, 32'(NUM_REGS * 4));

    // Ready depends only on registered state so the bridge never sees a combinational path
    assign ready    = (state_q == ACCESS) && (cnt_q == '0);
    assign rdVal    = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];

    assign PREADY    = ready;
    assign PSLVERROR = ready && err_q;
    assign PRDATA    = (ready && !err_q && !write_q) ? rdVal : 32'h0;
    assign wr_count  = wrCount_q;
    assign err_count = errCount_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        write_d    = write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        wrCount_d  = wrCount_q;
        errCount_d = errCount_q;
        regs_d     = regs_q;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    err_d   = dec.err;
                    idx_d   = IDX_W'(dec.idx);
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    cnt_d   = waitLoad;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE && ready) begin
                    state_d = IDLE;
                    if (err_q) begin
                        if (errCount_q != 8'hFF) errCount_d = errCount_q + 8'd1;
                    end else if (write_q) begin
                        for (int b = 0; b < 4; b++) begin
                            if (strb_q[b]) regs_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                        if (wrCount_q != 16'hFFFF) wrCount_d = wrCount_q + 16'd1;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            wrCount_q  <= '0;
            errCount_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            wrCount_q  <= wrCount_d;
            errCount_q <= errCount_d;
            regs_q     <= regs_d;
        end
    end

endmodule
